// File: rtl/dbus_region_router_pkg.sv
// Shared dbus types and region constants for the data-bus router.
//   dbus_req_t    : core -> downstream request (valid, addr, size, strobe, data)
//   dbus_resp_t   : downstream -> core response (addr_ok, data_ok, data)
//   router_port_t : symbolic names for the usual downstream port indices
//   REGION_UNCACHED_MASK/MATCH : the uncached window 0xA000_0000..0xBFFF_FFFF
package dbus_region_router_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [2:0] {
    PORT_DCACHE   = 3'd0,
    PORT_UNCACHED = 3'd1,
    PORT_MMIO     = 3'd2
  } router_port_t;

  localparam logic [31:0] REGION_UNCACHED_MASK  = 32'hE000_0000;
  localparam logic [31:0] REGION_UNCACHED_MATCH = 32'hA000_0000;

  function automatic logic region_hit(input logic [31:0] addr,
                                      input logic [31:0] mask,
                                      input logic [31:0] match);
    return (addr & mask) == match;
  endfunction

endpackage

// File: rtl/dbus_region_decode.sv
// Combinational address-region decoder: lowest-index port whose mask/match
// hits wins; the default port never matches by region and is the fallback.
//   addr : request address
//   sel  : selected port index
module dbus_region_decode
  import dbus_region_router_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter logic [NUM_PORTS-1:0][31:0] PORT_MASK  = {REGION_UNCACHED_MASK, 32'h0},
  parameter logic [NUM_PORTS-1:0][31:0] PORT_MATCH = {REGION_UNCACHED_MATCH, 32'h0},
  parameter int DEFAULT_PORT = 0,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [31:0]   addr,
  output logic [PW-1:0] sel
);

  // Scan from the top down so the lowest matching index is the last to write.
  always_comb begin
    sel = PW'(DEFAULT_PORT);
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (i != DEFAULT_PORT && region_hit(addr, PORT_MASK[i], PORT_MATCH[i])) begin
        sel = PW'(i);
      end
    end
  end

endmodule

// File: rtl/dbus_region_router.sv
// Steers one core dbus to NUM_PORTS downstream dbus ports by address region.
// Tracks accepted-but-unanswered requests and only moves ownership to a new
// port once the current owner is drained and not internally blocked.
//   clk, resetn : clock, asynchronous active-low reset
//   dreq/dresp  : core side request / response
//   port_req    : per-port requests (only the selected one is ever non-zero)
//   port_resp   : per-port responses
//   port_block  : per-port busy; the owner may not be left while it is set
//   cur_port    : port owning outstanding traffic
//   err         : sticky protocol error (stray or unmatched data_ok)
module dbus_region_router
  import dbus_region_router_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [NUM_PORTS-1:0][31:0] PORT_MASK  = {REGION_UNCACHED_MASK, 32'h0},
  parameter logic [NUM_PORTS-1:0][31:0] PORT_MATCH = {REGION_UNCACHED_MATCH, 32'h0},
  parameter int DEFAULT_PORT = 0,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  dbus_req_t                    dreq,
  output dbus_resp_t                   dresp,
  output dbus_req_t  [NUM_PORTS-1:0]   port_req,
  input  dbus_resp_t [NUM_PORTS-1:0]   port_resp,
  input  logic       [NUM_PORTS-1:0]   port_block,
  output logic       [PW-1:0]          cur_port,
  output logic                         err
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [PW-1:0] sel;
  logic [PW-1:0] rp;
  logic [PW-1:0] cur_port_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          err_q;
  logic          idle;
  logic          grant;
  logic          accept;
  logic          ret;
  logic          stray;

  dbus_region_decode #(
    .NUM_PORTS    (NUM_PORTS),
    .PORT_MASK    (PORT_MASK),
    .PORT_MATCH   (PORT_MATCH),
    .DEFAULT_PORT (DEFAULT_PORT)
  ) u_decode (
    .addr (dreq.addr),
    .sel  (sel)
  );

  assign idle = (cnt_q == '0);
  // While idle the response can only belong to a same-cycle pair on sel.
  assign rp   = idle ? sel : cur_port_q;

  // Outputs are forced quiet while reset is asserted so nothing leaks
  // downstream from a request the core holds through reset.
  always_comb begin
    grant = 1'b0;
    if (resetn && dreq.valid) begin
      if (idle) begin
        grant = !(port_block[cur_port_q] && (sel != cur_port_q));
      end else begin
        grant = (sel == cur_port_q) && (cnt_q < CNT_MAX);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_req[i] = '0;
      if (resetn && (PW'(i) == sel)) begin
        port_req[i]       = dreq;
        port_req[i].valid = grant;
      end
    end
  end

  always_comb begin
    dresp = '0;
    if (resetn) begin
      dresp.addr_ok = grant && port_resp[sel].addr_ok;
      dresp.data_ok = port_resp[rp].data_ok;
      dresp.data    = port_resp[rp].data;
    end
  end

  assign accept = dreq.valid && dresp.addr_ok;
  assign ret    = port_resp[rp].data_ok && (!idle || accept);

  always_comb begin
    stray = port_resp[rp].data_ok && idle && !accept;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if ((PW'(i) != rp) && port_resp[i].data_ok) begin
        stray = 1'b1;
      end
    end
  end

  // A return while full only frees the slot for the following cycle:
  // grant looks at cnt_q, never at cnt_d.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !ret) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!accept && ret) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_port_q <= PW'(DEFAULT_PORT);
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        cur_port_q <= sel;
      end
      if (stray) begin
        err_q <= 1'b1;
      end
    end
  end

  assign cur_port = cur_port_q;
  assign err      = err_q;

endmodule
